// File: rtl/quan_rr_sched_if.sv
// Bundles the lane request, config and quantization-unit signals of
// quan_rr_sched.
// master = the environment: lanes, config writer and quantization unit.
// slave  = the scheduler.
interface quan_rr_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) ();
  logic                    en;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*18-1:0]   req_data;
  logic [NUM_REQ-1:0]      req_ready;
  logic                    cfg_we;
  logic [ID_W-1:0]         cfg_id;
  logic [3:0]              cfg_shift;
  logic [7:0]              cfg_zp;
  logic [17:0]             q_din;
  logic [3:0]              q_shift;
  logic [7:0]              q_zero_point;
  logic [7:0]              q_dout;
  logic                    out_valid;
  logic [ID_W-1:0]         out_id;
  logic [7:0]              out_data;
  logic                    idle;

  modport master (
    output en, req_valid, req_data, cfg_we, cfg_id, cfg_shift, cfg_zp, q_dout,
    input  req_ready, q_din, q_shift, q_zero_point, out_valid, out_id, out_data, idle
  );

  modport slave (
    input  en, req_valid, req_data, cfg_we, cfg_id, cfg_shift, cfg_zp, q_dout,
    output req_ready, q_din, q_shift, q_zero_point, out_valid, out_id, out_data, idle
  );
endinterface

// File: rtl/quan_rr_sched.sv
// Round-robin scheduler that time-shares one fixed-latency INT18->INT8
// quantization unit among NUM_REQ lanes.
// Each lane's shift/zero_point is snapshotted at issue time and travels
// with the sample in a tag pipeline, so later config writes never disturb
// samples that are already in flight.
module quan_rr_sched #(
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = 2,
  parameter int LATENCY   = 5,
  parameter int SHIFT_DLY = 1
) (
  input  logic             clk,
  input  logic             rst,
  quan_rr_sched_if.slave   bus
);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic [3:0]      shift;
    logic [7:0]      zp;
  } tag_t;

  logic [3:0]      cfg_shift_q [NUM_REQ];
  logic [7:0]      cfg_zp_q    [NUM_REQ];
  logic [ID_W-1:0] last_grant;

  logic            grant_found;
  logic [ID_W-1:0] grant_id;
  int              idx;
  logic            issue;
  tag_t            tag0;
  // Stage k holds the tag of the sample issued k cycles ago; stage 0 is the
  // issue happening in the current cycle.
  tag_t            stage_q [1:LATENCY];
  logic            any_valid;

  // Round-robin search starting one past the last accepted lane.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!grant_found && bus.req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

  // Grant, sample mux and stage-0 tag for the current cycle.
  always_comb begin
    issue         = grant_found && bus.en && !rst;
    bus.req_ready = '0;
    bus.q_din     = '0;
    tag0          = '0;
    if (issue) begin
      bus.req_ready[grant_id] = 1'b1;
      bus.q_din               = bus.req_data[int'(grant_id)*18 +: 18];
      tag0.valid              = 1'b1;
      tag0.id                 = grant_id;
      tag0.shift              = cfg_shift_q[grant_id];
      tag0.zp                 = cfg_zp_q[grant_id];
    end
  end

  // Config table; a write is seen by issues from the next cycle on.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the table is small and must read back as zero after reset, so it is reset like ordinary flops rather than mapped to a RAM.
      for (int i = 0; i < NUM_REQ; i++) begin
        cfg_shift_q[i] <= '0;
        cfg_zp_q[i]    <= '0;
      end
    end else if (bus.cfg_we && (int'(bus.cfg_id) < NUM_REQ)) begin
      cfg_shift_q[bus.cfg_id] <= bus.cfg_shift;
      cfg_zp_q[bus.cfg_id]    <= bus.cfg_zp;
    end
  end

  // Pointer moves only on an accepted issue; reset gives lane 0 priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
      last_grant <= ID_W'(NUM_REQ - 1);
    end else if (issue) begin
      last_grant <= grant_id;
    end
  end

  // Tag pipeline advances every cycle, matching the non-stallable unit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 1; k <= LATENCY; k++) stage_q[k] <= '0;
    end else begin
      stage_q[1] <= tag0;
      for (int k = 2; k <= LATENCY; k++) stage_q[k] <= stage_q[k-1];
    end
  end

  // Unit-side parameters come from the stages where the unit samples them.
  always_comb begin
    bus.q_shift      = stage_q[SHIFT_DLY].valid ? stage_q[SHIFT_DLY].shift : 4'd0;
    bus.q_zero_point = stage_q[LATENCY].valid   ? stage_q[LATENCY].zp      : 8'd0;
  end

  // Register the result together with the lane id it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_id    <= '0;
      bus.out_data  <= '0;
    end else begin
      bus.out_valid <= stage_q[LATENCY].valid;
      if (stage_q[LATENCY].valid) begin
        bus.out_id   <= stage_q[LATENCY].id;
        bus.out_data <= bus.q_dout;
      end
    end
  end

  // Idle when nothing is in the pipeline and nothing issues this cycle.
  always_comb begin
    any_valid = 1'b0;
    for (int k = 1; k <= LATENCY; k++) any_valid = any_valid | stage_q[k].valid;
    bus.idle = !any_valid && !issue;
  end

endmodule

// File: tb/tb_quan_rr_sched.sv
// Self-checking bench for quan_rr_sched: models the quantization unit,
// tracks issues in a scoreboard queue and checks grants, unit-side
// parameters, result timing, ids and data every cycle.
module tb_quan_rr_sched;
  localparam int NUM_REQ   = 4;
  localparam int ID_W      = 2;
  localparam int LATENCY   = 5;
  localparam int SHIFT_DLY = 1;

  typedef struct {
    int              t;
    logic [ID_W-1:0] id;
    logic [7:0]      data;
    logic [3:0]      sh;
    logic [7:0]      zp;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  quan_rr_sched_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  quan_rr_sched #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .LATENCY(LATENCY), .SHIFT_DLY(SHIFT_DLY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [7:0] quant(input logic [17:0] d, input logic [3:0] sh,
                                       input logic [7:0] zp);
    int v;
    v = ($signed(d) >>> sh) + $signed(zp);
    if (v > 127) v = 127;
    else if (v < -128) v = -128;
    return v[7:0];
  endfunction

  // Quantization unit model: q_din sampled at issue, shift SHIFT_DLY later,
  // zero_point live in the output cycle.
  logic [17:0] dp [1:LATENCY];
  logic [3:0]  sp [1:LATENCY-SHIFT_DLY];
  always @(posedge clk) begin
    dp[1] <= bus.q_din;
    for (int k = 2; k <= LATENCY; k++) dp[k] <= dp[k-1];
    sp[1] <= bus.q_shift;
    for (int k = 2; k <= LATENCY - SHIFT_DLY; k++) sp[k] <= sp[k-1];
  end
  assign bus.q_dout = quant(dp[LATENCY], sp[LATENCY-SHIFT_DLY], bus.q_zero_point);

  // Reference config table and cycle counter.
  logic [3:0] m_shift [NUM_REQ];
  logic [7:0] m_zp    [NUM_REQ];
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        m_shift[i] = '0;
        m_zp[i]    = '0;
      end
    end else if (bus.cfg_we && int'(bus.cfg_id) < NUM_REQ) begin
      m_shift[bus.cfg_id] = bus.cfg_shift;
      m_zp[bus.cfg_id]    = bus.cfg_zp;
    end
  end

  // Per-cycle monitor and scoreboard.
  exp_t             sb[$];
  exp_t             e;
  int               m_last = NUM_REQ - 1;
  int               g, li;
  logic             found;
  logic [NUM_REQ-1:0] exp_ready;
  logic [17:0]      exp_din;
  logic [3:0]       exp_sh;
  logic [7:0]       exp_zp;
  always @(negedge clk) begin
    if (bus.out_valid) begin
      if (sb.size() == 0) begin
        check("out_unexpected", bus.out_valid, 1'b0);
      end else begin
        e = sb.pop_front();
        check("out_latency", cyc - e.t, LATENCY + 1);
        check("out_id", bus.out_id, e.id);
        check("out_data", bus.out_data, e.data);
      end
    end
    if (sb.size() > 0 && cyc - sb[0].t > LATENCY + 1) begin
      check("out_missing", cyc - sb[0].t, LATENCY + 1);
      void'(sb.pop_front());
    end
    exp_sh = '0;
    exp_zp = '0;
    foreach (sb[j]) begin
      if (sb[j].t == cyc - SHIFT_DLY) exp_sh = sb[j].sh;
      if (sb[j].t == cyc - LATENCY)   exp_zp = sb[j].zp;
    end
    check("q_shift", bus.q_shift, exp_sh);
    check("q_zero_point", bus.q_zero_point, exp_zp);

    found = 1'b0;
    g     = 0;
    if (!rst && bus.en) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        li = (m_last + k) % NUM_REQ;
        if (!found && bus.req_valid[li]) begin
          found = 1'b1;
          g     = li;
        end
      end
    end
    exp_ready = '0;
    exp_din   = '0;
    if (found) begin
      exp_ready[g] = 1'b1;
      exp_din      = bus.req_data[g*18 +: 18];
    end
    check("req_ready", bus.req_ready, exp_ready);
    check("q_din", bus.q_din, exp_din);
    check("idle", bus.idle, !found && sb.size() == 0);

    if (found) begin
      e.t    = cyc;
      e.id   = ID_W'(g);
      e.sh   = m_shift[g];
      e.zp   = m_zp[g];
      e.data = quant(exp_din, m_shift[g], m_zp[g]);
      sb.push_back(e);
      m_last = g;
    end
    if (rst) begin
      sb.delete();
      m_last = NUM_REQ - 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int lane, input logic [17:0] v);
    bus.req_data[lane*18 +: 18] = v;
  endtask

  task automatic cfg(input int id, input logic [3:0] sh, input logic [7:0] zp);
    bus.cfg_we    = 1'b1;
    bus.cfg_id    = ID_W'(id);
    bus.cfg_shift = sh;
    bus.cfg_zp    = zp;
  endtask

  initial begin
    logic [NUM_REQ-1:0] seq_a [8];
    logic [NUM_REQ-1:0] seq_b [4];
    seq_a = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    seq_b = '{4'b1000, 4'b0010, 4'b1000, 4'b0010};

    // Reset with all lanes requesting: nothing may be granted.
    rst = 1'b1;
    bus.en = 1'b1;
    bus.req_valid = '1;
    bus.req_data = '0;
    bus.cfg_we = 1'b0;
    bus.cfg_id = '0;
    bus.cfg_shift = '0;
    bus.cfg_zp = '0;
    repeat (2) tick();
    @(negedge clk);
    check("rst_req_ready", bus.req_ready, '0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_id", bus.out_id, '0);
    check("rst_out_data", bus.out_data, '0);
    check("rst_idle", bus.idle, 1'b1);

    // Single lane-1 sample with shift=2 zp=10.
    tick();
    rst = 1'b0;
    bus.req_valid = '0;
    cfg(1, 4'd2, 8'd10);
    tick();
    bus.cfg_we = 1'b0;
    bus.req_valid = 4'b0010;
    set_data(1, 18'd400);
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    check("t1_q_shift", bus.q_shift, 4'd2);
    repeat (4) tick();
    @(negedge clk);
    check("t5_q_zero_point", bus.q_zero_point, 8'd10);
    tick();
    @(negedge clk);
    check("t6_out_valid", bus.out_valid, 1'b1);
    check("t6_out_id", bus.out_id, 1);
    check("t6_out_data", bus.out_data, 8'd110);
    repeat (4) tick();

    // All lanes busy from reset: strict rotation 0,1,2,3,0,1,2,3.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req_valid = '1;
    for (int i = 0; i < 8; i++) begin
      for (int l = 0; l < NUM_REQ; l++) set_data(l, 18'($urandom));
      @(negedge clk);
      check("rr_all", bus.req_ready, seq_a[i]);
      tick();
    end
    bus.req_valid = '0;
    repeat (8) tick();

    // Lanes 1 and 3 only, after a lane-1 grant: 3,1,3,1.
    bus.req_valid = 4'b0010;
    set_data(1, 18'h3ffff);
    tick();
    bus.req_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      set_data(1, 18'($urandom));
      set_data(3, 18'($urandom));
      @(negedge clk);
      check("rr_1_3", bus.req_ready, seq_b[i]);
      tick();
    end
    bus.req_valid = '0;
    repeat (8) tick();

    // Config write in the same cycle as an issue does not affect it.
    cfg(2, 4'd1, 8'd3);
    tick();
    bus.req_valid = 4'b0100;
    set_data(2, 18'd1000);
    cfg(2, 4'd4, 8'hf0);
    tick();
    bus.cfg_we = 1'b0;
    set_data(2, 18'h3fc00);
    @(negedge clk);
    check("snap_old_shift", bus.q_shift, 4'd1);
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    check("snap_new_shift", bus.q_shift, 4'd4);
    repeat (8) tick();

    // en low blocks issue; raising it issues in that cycle.
    bus.en = 1'b0;
    bus.req_valid = 4'b0001;
    set_data(0, 18'd77);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("en_low_ready", bus.req_ready, '0);
      check("en_low_out_valid", bus.out_valid, 1'b0);
      tick();
    end
    bus.en = 1'b1;
    @(negedge clk);
    check("en_high_ready", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid = '0;
    repeat (8) tick();

    // Reset with three samples in flight discards them and clears config.
    bus.req_valid = 4'b0111;
    repeat (3) tick();
    bus.req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_rst_out_valid", bus.out_valid, 1'b0);
      check("post_rst_idle", bus.idle, 1'b1);
      tick();
    end
    bus.req_valid = 4'b0010;
    set_data(1, 18'd123);
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    check("post_rst_q_shift", bus.q_shift, 4'd0);
    repeat (4) tick();
    @(negedge clk);
    check("post_rst_q_zp", bus.q_zero_point, 8'd0);
    repeat (4) tick();

    // Mixed random traffic; the monitor checks every cycle.
    for (int i = 0; i < 300; i++) begin
      bus.en = ($urandom_range(0, 3) != 0);
      bus.req_valid = NUM_REQ'($urandom);
      for (int l = 0; l < NUM_REQ; l++) set_data(l, 18'($urandom));
      bus.cfg_we = ($urandom_range(0, 3) == 0);
      bus.cfg_id = ID_W'($urandom);
      bus.cfg_shift = 4'($urandom);
      bus.cfg_zp = 8'($urandom);
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    bus.cfg_we = 1'b0;
    bus.req_valid = '0;
    repeat (10) tick();
    @(negedge clk);
    check("final_drained", sb.size(), 0);
    check("final_idle", bus.idle, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
